// File: rtl/agu_arbiter.sv
// Round-robin arbiter/sequencer sharing one address generation unit among NUM_REQ requesters.
// Latches the winner's config, pulses agu_en once per sweep and counts beats locally.
module agu_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int VLEN       = 16384,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int OFF_WIDTH  = 8,
  parameter int CNT_WIDTH  = OFF_WIDTH + 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*2-1:0]            req_sew,
  input  logic [NUM_REQ*OFF_WIDTH-1:0]    req_max_off,
  input  logic [NUM_REQ*3-1:0]            req_max_reg,
  input  logic [NUM_REQ-1:0]              req_whole_reg,
  input  logic [NUM_REQ-1:0]              req_widen,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            agu_en,
  output logic [ADDR_WIDTH-1:0]           agu_addr,
  output logic [1:0]                      agu_sew,
  output logic [OFF_WIDTH-1:0]            agu_max_off,
  output logic [2:0]                      agu_max_reg,
  output logic                            agu_whole_reg,
  output logic                            agu_widen
);

  localparam int PTR_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEATS_PER_REG = VLEN / DATA_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr, rr_nxt, win;
  logic [CNT_WIDTH-1:0]   beat_cnt, cnt_nxt, beats, reg_beats, span;
  logic                   found, last_beat;
  logic [NUM_REQ-1:0]     avail, gnt_nxt, done_nxt;
  logic                   busy_nxt, en_nxt;
  logic [ADDR_WIDTH-1:0]  w_addr, addr_nxt;
  logic [1:0]             w_sew, sew_nxt;
  logic [OFF_WIDTH-1:0]   w_max_off, max_off_nxt;
  logic [2:0]             w_max_reg, max_reg_nxt;
  logic                   w_whole, w_widen, whole_nxt, widen_nxt;

  // The owner is masked off on its last beat so a waiting requester can be chained without a bubble.
  always_comb begin : arb
    int idx;
    idx       = 0;
    last_beat = (state == BUSY) && (beat_cnt == '0);
    avail     = req & ~(last_beat ? gnt : '0);
    found     = 1'b0;
    win       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && avail[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_addr    = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    w_sew     = req_sew[int'(win)*2 +: 2];
    w_max_off = req_max_off[int'(win)*OFF_WIDTH +: OFF_WIDTH];
    w_max_reg = req_max_reg[int'(win)*3 +: 3];
    w_whole   = req_whole_reg[win];
    w_widen   = req_widen[win];
    reg_beats = CNT_WIDTH'(BEATS_PER_REG) << w_sew;
    span      = (CNT_WIDTH'(w_max_reg) + CNT_WIDTH'(1)) * (CNT_WIDTH'(w_max_off) + CNT_WIDTH'(1));
    beats     = w_whole ? reg_beats : span;
    if (w_widen) beats = beats << 1;
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    cnt_nxt     = beat_cnt;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    busy_nxt    = busy;
    en_nxt      = 1'b0;
    addr_nxt    = agu_addr;
    sew_nxt     = agu_sew;
    max_off_nxt = agu_max_off;
    max_reg_nxt = agu_max_reg;
    whole_nxt   = agu_whole_reg;
    widen_nxt   = agu_widen;
    if (found && (state == IDLE || last_beat)) begin
      state_nxt   = BUSY;
      rr_nxt      = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      cnt_nxt     = beats - CNT_WIDTH'(1);
      gnt_nxt     = NUM_REQ'(1) << win;
      busy_nxt    = 1'b1;
      en_nxt      = 1'b1;
      addr_nxt    = w_addr;
      sew_nxt     = w_sew;
      max_off_nxt = w_max_off;
      max_reg_nxt = w_max_reg;
      whole_nxt   = w_whole;
      widen_nxt   = w_widen;
      if (beats == CNT_WIDTH'(1)) done_nxt = NUM_REQ'(1) << win;
    end else if (last_beat) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      busy_nxt  = 1'b0;
    end else if (state == BUSY) begin
      cnt_nxt = beat_cnt - CNT_WIDTH'(1);
      // done is registered, so it is raised on the edge that enters the last beat.
      if (beat_cnt == CNT_WIDTH'(1)) done_nxt = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      gnt           <= '0;
      done          <= '0;
      busy          <= 1'b0;
      agu_en        <= 1'b0;
      agu_addr      <= '0;
      agu_sew       <= '0;
      agu_max_off   <= '0;
      agu_max_reg   <= '0;
      agu_whole_reg <= 1'b0;
      agu_widen     <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_nxt;
      beat_cnt      <= cnt_nxt;
      gnt           <= gnt_nxt;
      done          <= done_nxt;
      busy          <= busy_nxt;
      agu_en        <= en_nxt;
      agu_addr      <= addr_nxt;
      agu_sew       <= sew_nxt;
      agu_max_off   <= max_off_nxt;
      agu_max_reg   <= max_reg_nxt;
      agu_whole_reg <= whole_nxt;
      agu_widen     <= widen_nxt;
    end
  end

endmodule

// File: tb/tb_agu_arbiter.sv
// Directed bench for agu_arbiter: single sweeps, widen, whole-register, chaining, idle gap, async reset.
module tb_agu_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*2-1:0] req_sew = '0;
  logic [NR*OW-1:0] req_max_off = '0;
  logic [NR*3-1:0] req_max_reg = '0;
  logic [NR-1:0]   req_whole_reg = '0;
  logic [NR-1:0]   req_widen = '0;
  logic [NR-1:0]   gnt, done;
  logic            busy, agu_en, agu_whole_reg, agu_widen;
  logic [AW-1:0]   agu_addr;
  logic [1:0]      agu_sew;
  logic [OW-1:0]   agu_max_off;
  logic [2:0]      agu_max_reg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  agu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_sew(req_sew),
    .req_max_off(req_max_off), .req_max_reg(req_max_reg), .req_whole_reg(req_whole_reg),
    .req_widen(req_widen), .gnt(gnt), .done(done), .busy(busy), .agu_en(agu_en),
    .agu_addr(agu_addr), .agu_sew(agu_sew), .agu_max_off(agu_max_off),
    .agu_max_reg(agu_max_reg), .agu_whole_reg(agu_whole_reg), .agu_widen(agu_widen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int i, input logic [AW-1:0] a, input logic [1:0] s,
                     input logic [OW-1:0] mo, input logic [2:0] mr,
                     input logic wr, input logic wd);
    req_addr[i*AW +: AW]   = a;
    req_sew[i*2 +: 2]      = s;
    req_max_off[i*OW +: OW] = mo;
    req_max_reg[i*3 +: 3]  = mr;
    req_whole_reg[i]       = wr;
    req_widen[i]           = wd;
  endtask

  // Follows one owner from its agu_en cycle until gnt drops; the requester releases req on done.
  task automatic sweep(input logic [NR-1:0] onehot, input logic exp_wd,
                       output int gcyc, output int done_at, output int en_cnt, output int wd_bad);
    int budget;
    budget = 3000;
    gcyc = 0; done_at = 0; en_cnt = 0; wd_bad = 0;
    while (gnt == onehot && budget > 0) begin
      gcyc++;
      if (done == onehot) begin
        done_at = gcyc;
        req = req & ~onehot;
      end
      if (agu_en) en_cnt++;
      if (agu_widen !== exp_wd) wd_bad++;
      step();
      budget--;
    end
  endtask

  int gc, da, ec, wb;
  int chain_gnt[7]  = '{1, 1, 2, 2, 4, 4, 0};
  int chain_en[7]   = '{1, 0, 1, 0, 1, 0, 0};
  int chain_done[7] = '{0, 1, 0, 2, 0, 4, 0};
  int solo_gnt[4]   = '{2, 2, 0, 2};
  int solo_en[4]    = '{1, 0, 0, 1};
  int solo_done[4]  = '{0, 2, 0, 0};
  int solo_busy[4]  = '{1, 1, 0, 1};

  initial begin
    // reset state
    step(); step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(agu_en), 0);
    chk("rst_addr", 32'(agu_addr), 0);
    rst_n = 1'b1;
    step();

    // N = 2*4 = 8
    cfg(0, 5'd5, 2'd1, 8'd3, 3'd1, 1'b0, 1'b0);
    req = 3'b001;
    step();
    chk("s1_en", 32'(agu_en), 1);
    chk("s1_gnt", 32'(gnt), 1);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_addr", 32'(agu_addr), 5);
    chk("s1_sew", 32'(agu_sew), 1);
    chk("s1_max_off", 32'(agu_max_off), 3);
    chk("s1_max_reg", 32'(agu_max_reg), 1);
    chk("s1_done0", 32'(done), 0);
    sweep(3'b001, 1'b0, gc, da, ec, wb);
    chk("s1_gnt_cycles", 32'(gc), 8);
    chk("s1_done_at", 32'(da), 8);
    chk("s1_en_cycles", 32'(ec), 1);
    chk("s1_busy_after", 32'(busy), 0);
    chk("s1_gnt_after", 32'(gnt), 0);

    // widen doubles to 16
    cfg(0, 5'd5, 2'd1, 8'd3, 3'd1, 1'b0, 1'b1);
    req = 3'b001;
    step();
    sweep(3'b001, 1'b1, gc, da, ec, wb);
    chk("s2_gnt_cycles", 32'(gc), 16);
    chk("s2_done_at", 32'(da), 16);
    chk("s2_widen_held", 32'(wb), 0);
    chk("s2_en_cycles", 32'(ec), 1);

    // whole register, sew=2: 4*256 = 1024
    cfg(0, 5'd9, 2'd2, 8'd3, 3'd1, 1'b1, 1'b0);
    req = 3'b001;
    step();
    chk("s3_max_reg", 32'(agu_max_reg), 1);
    chk("s3_max_off", 32'(agu_max_off), 3);
    chk("s3_whole", 32'(agu_whole_reg), 1);
    chk("s3_addr", 32'(agu_addr), 9);
    sweep(3'b001, 1'b0, gc, da, ec, wb);
    chk("s3_gnt_cycles", 32'(gc), 1024);
    chk("s3_done_at", 32'(da), 1024);

    // three requesters chained back-to-back, N=2 each
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) cfg(i, 5'(i + 1), 2'd0, 8'd1, 3'd0, 1'b0, 1'b0);
    req = 3'b111;
    for (int c = 0; c < 7; c++) begin
      step();
      chk($sformatf("chain_gnt_c%0d", c + 1), 32'(gnt), 32'(chain_gnt[c]));
      chk($sformatf("chain_en_c%0d", c + 1), 32'(agu_en), 32'(chain_en[c]));
      chk($sformatf("chain_done_c%0d", c + 1), 32'(done), 32'(chain_done[c]));
      req = req & ~done;
    end
    chk("chain_rr_ptr", 32'(dut.rr_ptr), 0);

    // sole requester 1 holding req: one idle cycle between sweeps
    req = 3'b010;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("solo_gnt_c%0d", c + 1), 32'(gnt), 32'(solo_gnt[c]));
      chk($sformatf("solo_en_c%0d", c + 1), 32'(agu_en), 32'(solo_en[c]));
      chk($sformatf("solo_done_c%0d", c + 1), 32'(done), 32'(solo_done[c]));
      chk($sformatf("solo_busy_c%0d", c + 1), 32'(busy), 32'(solo_busy[c]));
    end

    // asynchronous reset in the middle of that sweep
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_en", 32'(agu_en), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_addr", 32'(agu_addr), 0);
    chk("arst_rr_ptr", 32'(dut.rr_ptr), 0);
    req = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 32'(gnt), 2);
    chk("post_rst_en", 32'(agu_en), 1);
    chk("post_rst_addr", 32'(agu_addr), 2);
    req = 3'b000;
    step(); step(); step();
    chk("final_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
